nibble_serial_addsub: RTL
=========================

// Module: nibble_serial_addsub
// PURPOSE
//  Multi-cycle W-bit add/subtract controller built around the existing 4-bit combinational adder stage.
//  It processes one nibble per clock, least significant first. For each nibble it drives the adder's A, B and
//  carry-in pins, then captures the adder's sum and carry-out, and feeds the carry back to the next nibble.
//  It sits directly upstream and downstream of the adder: it feeds the operands and consumes the sum and carry.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices; operand width W = 4*NIBBLES (NIBBLES >= 1)
// PORTS
//  clk         in   1  single clock, all state updates on the rising edge
//  rst         in   1  synchronous, active-high reset
//  in_start    in   1  request; sampled only in IDLE
//  in_sub      in   1  0 = A+B, 1 = A-B; sampled together with in_start
//  in_a        in   W  operand A; sampled together with in_start
//  in_b        in   W  operand B; sampled together with in_start
//  out_busy    out  1  high in RUN and DONE
//  out_done    out  1  one-cycle pulse; result and flags valid from this cycle
//  out_result  out  W  sum or difference, held until the next accepted start
//  out_carry   out  1  final carry-out (for subtraction: 1 = no borrow, A>=B unsigned)
//  out_ovf     out  1  two's-complement signed overflow
//  out_zero    out  1  out_result == 0
//  add_a       out  4  to adder A pins: current nibble of latched A
//  add_b       out  4  to adder B pins: current nibble of latched B, inverted if sub
//  add_cin     out  1  to adder carry-in pin: carry register
//  add_s       in   4  from adder sum pins
//  add_cout    in   1  from adder carry-out pin
// BEHAVIOUR
//  State machine, 2-bit state, states IDLE/RUN/DONE; nibble index idx of width clog2(NIBBLES) (min 1 bit).
//  Reset (synchronous, takes priority over all other events):
//   - state=IDLE, idx=0, carry_reg=0
//   - out_result=0, out_carry=0, out_ovf=0, out_zero=0 (out_zero=0 under reset, not 1)
//   - out_busy=0, out_done=0
//  IDLE:
//   - add_a, add_b, add_cin driven to 0
//   - on in_start=1: opA<=in_a; opB<=in_sub ? ~in_b : in_b; carry_reg<=in_sub; idx<=0; state<=RUN
//   - in_sub, in_a, in_b are ignored when in_start=0
//  RUN:
//   - add_a = opA[4*idx+:4], add_b = opB[4*idx+:4], add_cin = carry_reg (combinational from registers)
//   - each edge: out_result[4*idx+:4] <= add_s; carry_reg <= add_cout
//   - if idx==NIBBLES-1: state<=DONE, else idx<=idx+1
//   - the adder is treated as purely combinational within one cycle; no extra wait cycle
//  On the RUN->DONE edge, flags register:
//   - out_carry = add_cout
//   - out_ovf = (opA[W-1]==opB[W-1]) && (add_s[3]!=opA[W-1])  (opB already inverted for sub)
//   - out_zero = ({add_s, lower result nibbles} == 0)
//  DONE:
//   - out_done=1 for exactly one cycle; adder pins driven to 0; next state IDLE unconditionally
//  Latency:
//   - start accepted at edge T0 -> out_done high in cycle T0+NIBBLES+1 -> new start accepted at T0+NIBBLES+2 at the earliest
//  out_result and flags:
//   - the lower nibbles update progressively during RUN; only the value while out_done=1 (or later, while held) is valid
//   - on the next accepted start, out_result and flags keep their old values until overwritten nibble by nibble
//  Edge cases:
//   - in_start while busy is ignored: no queueing, no effect on the operation in flight
//   - rst asserted mid-RUN: operation aborted, no out_done pulse, all outputs return to reset values
//   - NIBBLES=1: a single RUN cycle
//   - subtracting B=0: carry_reg=1 and opB=all ones, so out_carry=1 and the result equals A
// TESTING (NIBBLES=4, adder model connected)
//  1. add 0x1234+0x0FCD -> done after 5 cycles; result 0x2201, carry 0, ovf 0, zero 0
//  2. add 0xFFFF+0x0001 -> result 0x0000, carry 1, ovf 0, zero 1; add 0x7FFF+0x0001 -> 0x8000, ovf 1, carry 0
//  3. sub 0x0005-0x0007 -> result 0xFFFE, carry 0 (borrow), ovf 0; sub 0x8000-0x0001 -> 0x7FFF, carry 1, ovf 1
//  4. pulse in_start with a different A/B during RUN -> ignored; first result unchanged; exactly one out_done pulse
//  5. rst at second RUN cycle -> next cycle busy=0, result=0, no done pulse; a following start computes correctly
//  6. back-to-back: start held high continuously -> ops accepted every 6 cycles; check the add_a/add_b/add_cin sequence per nibble

Source files
------------

// File: rtl/nibble_serial_addsub_if.sv
// Bundle of the request/result handshake and the 4-bit adder pins used by
// nibble_serial_addsub. The controller takes the slave view; whatever sits
// on the other side (host logic plus the adder stage) takes the master view.
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // Request side
    logic         in_start;
    logic         in_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    // Result side
    logic         out_busy;
    logic         out_done;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_ovf;
    logic         out_zero;

    // 4-bit combinational adder pins
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    modport slave (
        input  in_start, in_sub, in_a, in_b,
        output out_busy, out_done, out_result, out_carry, out_ovf, out_zero,
        output add_a, add_b, add_cin,
        input  add_s, add_cout
    );

    modport master (
        output in_start, in_sub, in_a, in_b,
        input  out_busy, out_done, out_result, out_carry, out_ovf, out_zero,
        input  add_a, add_b, add_cin,
        output add_s, add_cout
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/subtract controller wrapped around an external 4-bit
// combinational adder. One nibble is processed per clock, least significant
// first; the adder's carry-out is registered and fed back as the next
// nibble's carry-in. Subtraction is A + ~B + 1, so the operand B is inverted
// once at accept time and the initial carry is seeded with in_sub.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_addsub_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Control state
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;

    // Latched operands (B already conditionally inverted)
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;

    // Result and flags, held until overwritten by the next operation
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    // Current nibble of each latched operand
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;

    // Select the operand nibbles addressed by idx
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                nib_a = opa_q[4*n +: 4];
                nib_b = opb_q[4*n +: 4];
            end
        end
    end

    // Adder pins carry live operands only while running; idle otherwise
    assign bus.add_a   = (state_q == S_RUN) ? nib_a   : 4'd0;
    assign bus.add_b   = (state_q == S_RUN) ? nib_b   : 4'd0;
    assign bus.add_cin = (state_q == S_RUN) ? carry_q : 1'b0;

    assign bus.out_busy   = (state_q != S_IDLE);
    assign bus.out_done   = (state_q == S_DONE);
    assign bus.out_result = result_q;
    assign bus.out_carry  = cout_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_zero   = zero_q;

    // Next-state logic for the IDLE/RUN/DONE sequencer and the result path
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_start) begin
                    opa_d   = bus.in_a;
                    opb_d   = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                carry_d = bus.add_cout;
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IW'(n)) begin
                        result_d[4*n +: 4] = bus.add_s;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    // Final nibble: all lower nibbles of result_d are now
                    // from this operation, so the flags can be formed here.
                    state_d = S_DONE;
                    cout_d  = bus.add_cout;
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) &&
                              (bus.add_s[3] != opa_q[W-1]);
                    zero_d  = (result_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control, result and flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Operand registers: only meaningful after an accepted start
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
    end
endmodule
